jtframe_blank_prog: RTL and testbench
=====================================

// Module: jtframe_blank_prog
// PURPOSE
//  Runtime-programmable video delay/blanking stage between core colour output and jtframe scaler/OSD.
//  Delays RGB, LHBL, LVBL, HS and VS by 0..MAXDLY-1 pixel enables using a ring buffer.
//  Blanked pixels are forced to a fill colour. Delay changes take effect only at the input VBLANK start.
//  Generalises the fixed-delay blanker: multi-channel colour, sync delay, fill colour, safe start-up.
// PARAMETERS
//  MAXDLY  16     ring depth. Power of 2, >=2. Legal dly range is 0..MAXDLY-1.
//  CW      4      bits per colour channel.
//  CH      3      number of colour channels. Total colour width DW=CH*CW.
//  AW      derived $clog2(MAXDLY). Not to be overridden.
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous reset, active high
//  pxl_cen   in   1      pixel clock enable; all state advances only when high (except rst)
//  dly       in   AW     requested delay in pixel enables
//  fill_en   in   1      1: blanked pixels output fill; 0: blanked pixels output 0
//  fill      in   DW     fill colour
//  LHBL      in   1      horizontal blank, active low
//  LVBL      in   1      vertical blank, active low
//  HS        in   1      horizontal sync, active high
//  VS        in   1      vertical sync, active high
//  rgb_in    in   DW     pixel colour, channel 0 in LSBs
//  LHBL_dly  out  1      delayed LHBL
//  LVBL_dly  out  1      delayed LVBL
//  HS_dly    out  1      delayed HS
//  VS_dly    out  1      delayed VS
//  preLBL    out  1      combinational: LHBL_dly&LVBL_dly value to be latched at next pxl_cen
//  rgb_out   out  DW     delayed colour, blanked
//  dly_act   out  AW     delay currently in force
//  ready     out  1      1 once the ring holds at least dly_act+1 valid entries since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge clk, regardless of pxl_cen):
//   - wr_ptr=0, fill_cnt=0, dly_act<=dly, ready=0
//   - all delayed outputs = 0: LHBL_dly, LVBL_dly, HS_dly, VS_dly, rgb_out
//   - ring contents are not cleared
//  Ring buffer:
//   - MAXDLY entries of {HS,VS,LHBL,LVBL,rgb_in}; asynchronous read
//   - each pxl_cen: entry written at wr_ptr, then wr_ptr++ (mod MAXDLY wrap)
//   - fill_cnt saturates at MAXDLY, incremented on each pxl_cen
//  Tap selection:
//   - dly_act=0: tap = current inputs (bypass)
//   - otherwise: tap = ring[wr_ptr-dly_act], AW-bit modular subtraction
//  Latency: registered outputs after pxl_cen edge k reflect inputs sampled at pxl_cen edge k-dly_act.
//   - dly_act=0 therefore gives one-register latency, same as a plain blanker
//  Output update on pxl_cen:
//   - {HS_dly,VS_dly,LHBL_dly,LVBL_dly} <= tap sync/blank bits
//   - rgb_out <= (tap LHBL & tap LVBL) ? tap rgb : (fill_en ? fill : 0)
//   - preLBL = tap LHBL & tap LVBL, combinational; forced 0 while ready=0
//  Start-up gating:
//   - ready = (fill_cnt > dly_act), registered
//   - while ready=0, outputs load the reset values instead of the tap, so stale ring data never escapes
//  Delay change:
//   - dly is sampled only on pxl_cen when input LVBL goes 1->0 (previous LVBL registered on pxl_cen)
//   - dly_act <= dly at that edge; changes elsewhere in the frame are ignored
//   - an edge coincident with a new dly value uses the new value
//   - a change that raises dly_act above fill_cnt-1 drops ready to 0 until refilled
//   - new tap is used from the next pxl_cen
//  Inputs pxl_cen=0: nothing changes; rst mid-frame restarts the fill sequence.
// TESTING
//  1 rst, dly=0, LHBL=LVBL=1, rgb ramp, fill_en=0 -> rgb_out after cen k equals rgb_in at cen k; ready=1 after 1st cen.
//  2 dly=5 at reset, ramp -> outputs 0 and ready=0 for 5 cens; then rgb_out(k)=rgb_in(k-5), HS/VS/blank delayed by 5.
//  3 dly=3, LHBL=0 for 10 px, fill_en=1, fill=12'hF0F -> rgb_out=12'hF0F on exactly 10 cens; preLBL leads LHBL_dly by one cen.
//  4 dly changes 2->7 mid-frame -> dly_act stays 2 until LVBL falls; then latency becomes 7 at the next cen.
//  5 dly=MAXDLY-1, 3*MAXDLY cens -> wr_ptr wraps; rgb_out(k)=rgb_in(k-15) with no glitch at wrap.
//  6 pxl_cen toggled 1-in-4, then rst asserted mid-line -> outputs frozen between cens; rst clears outputs and ready in one clk.

Source files
------------

// File: rtl/jtframe_blank_prog.sv
// Programmable ring-buffer delay for colour, blanking and sync, with blank fill
// colour and start-up gating so stale ring contents never reach the outputs.
module jtframe_blank_prog #(
   parameter int MAXDLY = 16,
   parameter int CW     = 4,
   parameter int CH     = 3,
   localparam int AW    = $clog2(MAXDLY),
   localparam int DW    = CH*CW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic [AW-1:0] dly,
   input  logic          fill_en,
   input  logic [DW-1:0] fill,
   input  logic          LHBL,
   input  logic          LVBL,
   input  logic          HS,
   input  logic          VS,
   input  logic [DW-1:0] rgb_in,
   output logic          LHBL_dly,
   output logic          LVBL_dly,
   output logic          HS_dly,
   output logic          VS_dly,
   output logic          preLBL,
   output logic [DW-1:0] rgb_out,
   output logic [AW-1:0] dly_act,
   output logic          ready
);

   localparam int EW = DW + 4;
   localparam logic [AW:0] FULL = (AW+1)'(MAXDLY);

   // Entry layout: {HS, VS, LHBL, LVBL, rgb}
   logic [EW-1:0] ring [MAXDLY];

   logic [AW-1:0] wr_ptr_reg, dly_act_reg, rd_ptr;
   logic [AW:0]   fill_cnt_reg;
   logic          lvbl_prev_reg, ready_reg;
   logic          lhbl_dly_reg, lvbl_dly_reg, hs_dly_reg, vs_dly_reg;
   logic [DW-1:0] rgb_out_reg, rgb_blank;
   logic [EW-1:0] cur, tap;
   logic          tap_valid, tap_lbl, vb_fall;

   always_comb begin
      cur       = {HS, VS, LHBL, LVBL, rgb_in};
      rd_ptr    = wr_ptr_reg - dly_act_reg;
      tap       = (dly_act_reg == '0) ? cur : ring[rd_ptr];
      // The tap holds real data once at least dly_act entries precede it
      tap_valid = fill_cnt_reg >= {1'b0, dly_act_reg};
      tap_lbl   = tap[DW+1] & tap[DW];
      vb_fall   = lvbl_prev_reg & ~LVBL;
   end

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_blank
         assign rgb_blank[gi*CW +: CW] = tap_lbl ? tap[gi*CW +: CW] :
                                         (fill_en ? fill[gi*CW +: CW] : '0);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (pxl_cen) ring[wr_ptr_reg] <= cur;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         fill_cnt_reg  <= '0;
         dly_act_reg   <= dly;
         ready_reg     <= 1'b0;
         lvbl_prev_reg <= 1'b0;
         lhbl_dly_reg  <= 1'b0;
         lvbl_dly_reg  <= 1'b0;
         hs_dly_reg    <= 1'b0;
         vs_dly_reg    <= 1'b0;
         rgb_out_reg   <= '0;
      end else if (pxl_cen) begin
         wr_ptr_reg    <= wr_ptr_reg + 1'b1;
         if (fill_cnt_reg != FULL) fill_cnt_reg <= fill_cnt_reg + 1'b1;
         lvbl_prev_reg <= LVBL;
         if (vb_fall) dly_act_reg <= dly;
         ready_reg     <= tap_valid;
         if (tap_valid) begin
            hs_dly_reg   <= tap[DW+3];
            vs_dly_reg   <= tap[DW+2];
            lhbl_dly_reg <= tap[DW+1];
            lvbl_dly_reg <= tap[DW];
            rgb_out_reg  <= rgb_blank;
         end else begin
            hs_dly_reg   <= 1'b0;
            vs_dly_reg   <= 1'b0;
            lhbl_dly_reg <= 1'b0;
            lvbl_dly_reg <= 1'b0;
            rgb_out_reg  <= '0;
         end
      end
   end

   // preLBL is gated like the outputs so it always equals the value about to be latched
   assign preLBL   = tap_valid & tap_lbl;
   assign LHBL_dly = lhbl_dly_reg;
   assign LVBL_dly = lvbl_dly_reg;
   assign HS_dly   = hs_dly_reg;
   assign VS_dly   = vs_dly_reg;
   assign rgb_out  = rgb_out_reg;
   assign dly_act  = dly_act_reg;
   assign ready    = ready_reg;

endmodule

// File: tb/tb_jtframe_blank_prog.sv
// Bench for jtframe_blank_prog: hand-computed vector table plus directed
// sequences checked against a per-pixel input history.
module tb_jtframe_blank_prog;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pxl_cen = 1'b0;
   logic [3:0]  dly = '0;
   logic        fill_en = 1'b0;
   logic [11:0] fill = '0;
   logic        LHBL = 1'b1, LVBL = 1'b1, HS = 1'b0, VS = 1'b0;
   logic [11:0] rgb_in = '0;
   logic        LHBL_dly, LVBL_dly, HS_dly, VS_dly, preLBL, ready;
   logic [11:0] rgb_out;
   logic [3:0]  dly_act;

   jtframe_blank_prog #(.MAXDLY(16), .CW(4), .CH(3)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .dly(dly), .fill_en(fill_en),
      .fill(fill), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS), .rgb_in(rgb_in),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .HS_dly(HS_dly), .VS_dly(VS_dly),
      .preLBL(preLBL), .rgb_out(rgb_out), .dly_act(dly_act), .ready(ready)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int k = 0;                    // pixel enables since last reset
   logic [15:0] hist [0:255];    // {HS,VS,LHBL,LVBL,rgb} per pixel enable
   logic pre_s;

   typedef struct {
      logic [11:0] rgb; logic hs, vs, lh, lv;
      logic [11:0] e_rgb; logic e_hs, e_vs, e_lh, e_lv, e_rdy;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [11:0] r, input logic h, input logic v,
                         input logic lh, input logic lv);
      rgb_in = r; HS = h; VS = v; LHBL = lh; LVBL = lv;
   endtask

   task automatic step(input logic cen);
      if (cen) hist[k] = {HS, VS, LHBL, LVBL, rgb_in};
      pxl_cen = cen;
      #1;
      pre_s = preLBL;
      @(posedge clk);
      #1;
      pxl_cen = 1'b0;
      if (cen) k++;
   endtask

   task automatic do_reset(input logic [3:0] d);
      dly = d; rst = 1'b1; pxl_cen = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; k = 0;
   endtask

   // Outputs after the latest pixel enable, given delay d in force at that enable
   task automatic check_model(input int d, input string tag);
      int idx;
      logic [15:0] e;
      logic [11:0] er;
      logic er_rdy;
      idx = k - 1;
      if (idx < d) begin
         e = '0; er = '0; er_rdy = 1'b0;
      end else begin
         e = hist[idx-d];
         er = (e[13] & e[12]) ? e[11:0] : (fill_en ? fill : 12'h000);
         er_rdy = 1'b1;
      end
      chk({tag, ".rgb"}, 32'(rgb_out), 32'(er));
      chk({tag, ".sync"}, 32'({HS_dly, VS_dly, LHBL_dly, LVBL_dly}), 32'(e[15:12]));
      chk({tag, ".ready"}, 32'(ready), 32'(er_rdy));
      $display("%s k=%0d d=%0d rgb_out=%03h ready=%0b", tag, idx, d, rgb_out, ready);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      // Test 2 vectors, dly=5: outputs held at 0 for five enables, then inputs delayed by five
      tbl[0] = '{12'h100, 0,0,1,1, 12'h000, 0,0,0,0, 0};
      tbl[1] = '{12'h101, 1,0,1,1, 12'h000, 0,0,0,0, 0};
      tbl[2] = '{12'h102, 0,1,1,1, 12'h000, 0,0,0,0, 0};
      tbl[3] = '{12'h103, 0,0,0,1, 12'h000, 0,0,0,0, 0};
      tbl[4] = '{12'h104, 0,0,1,1, 12'h000, 0,0,0,0, 0};
      tbl[5] = '{12'h105, 0,0,1,1, 12'h100, 0,0,1,1, 1};
      tbl[6] = '{12'h106, 0,0,1,1, 12'h101, 1,0,1,1, 1};
      tbl[7] = '{12'h107, 0,0,1,1, 12'h102, 0,1,1,1, 1};
      tbl[8] = '{12'h108, 0,0,1,1, 12'h000, 0,0,0,1, 1};
      tbl[9] = '{12'h109, 0,0,1,1, 12'h104, 0,0,1,1, 1};

      // Reset state
      set_in(12'h3A5, 1, 1, 1, 1);
      do_reset(4'd0);
      chk("rst.rgb", 32'(rgb_out), 32'h0);
      chk("rst.sync", 32'({HS_dly, VS_dly, LHBL_dly, LVBL_dly}), 32'h0);
      chk("rst.ready", 32'(ready), 32'h0);
      chk("rst.dly_act", 32'(dly_act), 32'h0);
      $display("reset: rgb_out=%03h ready=%0b dly_act=%0d", rgb_out, ready, dly_act);

      // Test 1: bypass delay, one-register latency
      for (int i = 0; i < 20; i++) begin
         set_in(12'(i * 7 + 1), i[1], i[4], 1, 1);
         step(1);
         check_model(0, "t1");
      end

      // Test 2: table-driven, dly=5
      set_in(12'h000, 0, 0, 1, 1);
      do_reset(4'd5);
      chk("t2.dly_act", 32'(dly_act), 32'd5);
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].rgb, tbl[i].hs, tbl[i].vs, tbl[i].lh, tbl[i].lv);
         step(1);
         chk($sformatf("t2[%0d].rgb", i), 32'(rgb_out), 32'(tbl[i].e_rgb));
         chk($sformatf("t2[%0d].sync", i), 32'({HS_dly, VS_dly, LHBL_dly, LVBL_dly}),
             32'({tbl[i].e_hs, tbl[i].e_vs, tbl[i].e_lh, tbl[i].e_lv}));
         chk($sformatf("t2[%0d].ready", i), 32'(ready), 32'(tbl[i].e_rdy));
         $display("t2[%0d] rgb_out=%03h ready=%0b", i, rgb_out, ready);
      end

      // Test 3: horizontal blank with fill colour, preLBL leads LHBL_dly
      fill_en = 1'b1; fill = 12'hF0F;
      set_in(12'h000, 0, 0, 1, 1);
      do_reset(4'd3);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         set_in(12'(i), 0, 0, !(i >= 8 && i < 18), 1);
         step(1);
         check_model(3, "t3");
         chk("t3.prelbl", 32'(LHBL_dly & LVBL_dly), 32'(pre_s));
         if (rgb_out == 12'hF0F) cnt++;
      end
      chk("t3.fill_count", 32'(cnt), 32'd10);
      fill_en = 1'b0; fill = '0;

      // Test 4: delay change 2 -> 7 applied only at the LVBL fall
      set_in(12'h000, 0, 0, 1, 1);
      do_reset(4'd2);
      for (int i = 0; i < 20; i++) begin
         set_in(12'(12'h400 + i), i[0], 0, 1, 1);
         step(1);
         check_model(2, "t4a");
      end
      dly = 4'd7;
      for (int i = 20; i < 25; i++) begin
         set_in(12'(12'h400 + i), i[0], 0, 1, 1);
         step(1);
         check_model(2, "t4b");
      end
      chk("t4.dly_hold", 32'(dly_act), 32'd2);
      set_in(12'h419, 0, 0, 1, 0);
      step(1);
      check_model(2, "t4fall");
      chk("t4.dly_new", 32'(dly_act), 32'd7);
      for (int i = 26; i < 40; i++) begin
         set_in(12'(12'h400 + i), i[0], 0, 1, 1);
         step(1);
         check_model(7, "t4c");
      end

      // Test 5: maximum delay across several pointer wraps
      set_in(12'h000, 0, 0, 1, 1);
      do_reset(4'd15);
      for (int i = 0; i < 48; i++) begin
         set_in(12'(12'h800 + i * 3), i[2], i[3], 1, 1);
         step(1);
         check_model(15, "t5");
      end

      // Test 6: sparse pixel enables hold outputs; reset mid-line clears in one clk
      set_in(12'h000, 0, 0, 1, 1);
      do_reset(4'd1);
      for (int i = 0; i < 24; i++) begin
         if (i % 4 == 3) set_in(12'(12'h200 + i), i[2], 1, 1, 1);
         step(i % 4 == 3);
         check_model(1, "t6");
      end
      rst = 1'b1; pxl_cen = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; k = 0;
      chk("t6.rst.rgb", 32'(rgb_out), 32'h0);
      chk("t6.rst.sync", 32'({HS_dly, VS_dly, LHBL_dly, LVBL_dly}), 32'h0);
      chk("t6.rst.ready", 32'(ready), 32'h0);
      $display("t6 reset: rgb_out=%03h ready=%0b", rgb_out, ready);
      for (int i = 0; i < 4; i++) begin
         set_in(12'(12'h300 + i), 0, 0, 1, 1);
         step(1);
         check_model(1, "t6r");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
